// File: rtl/tile_pkg.sv
// Shared tile definitions for the row generator and the input checker.
package tile_pkg;

  typedef logic [2:0] tile_t;

  // Tile codes: one lane per key, 101-111 are never produced.
  localparam tile_t TILE_EMPTY = 3'b000;
  localparam tile_t TILE_K3    = 3'b001;
  localparam tile_t TILE_K2    = 3'b010;
  localparam tile_t TILE_K1    = 3'b011;
  localparam tile_t TILE_K0    = 3'b100;

  // Scroll handshake states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } shift_state_e;

  // Fibonacci taps 16, 14, 13, 11 expressed as bit positions 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

  // One left shift with the XOR of the tapped bits entering at bit 0.
  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAP_MASK)};
  endfunction

  // Map two random bits to a lane 1..4, rotating by one lane when it would
  // repeat the lane currently on top of the board.
  function automatic tile_t pick_lane(logic [1:0] bits, tile_t top);
    tile_t lane;
    lane = tile_t'({1'b0, bits}) + 3'd1;
    if (lane == top) begin
      lane = tile_t'({1'b0, bits + 2'd1}) + 3'd1;
    end
    return lane;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR advanced one step per request; a zero seed becomes 1
// so the register can never lock up at zero.
module lfsr16
  import tile_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] seed_fixed;
  logic [15:0] value_q;
  logic [15:0] value_d;

  // Substitute a legal seed for the all-zero lock-up state.
  always_comb begin
    seed_fixed = seed;
    if (seed == 16'h0000) begin
      seed_fixed = 16'h0001;
    end
  end

  // Next-state: advance only when stepped.
  always_comb begin
    value_d = value_q;
    if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  // State register with synchronous reset to the (fixed) seed.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= seed_fixed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/tile_row_gen.sv
// Scrolling tile board: on each go/done handshake every row moves down one
// slot, a fresh pseudo-random row enters at the top and an unplayed tile
// leaving the bottom row is reported as a miss.
module tile_row_gen
  import tile_pkg::*;
#(
  parameter int unsigned NUM_ROWS  = 7,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned EMPTY_MOD = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  shift_go,
  output logic                  shift_done,
  input  logic                  clear_bottom,
  output logic [3*NUM_ROWS-1:0] rows,
  output logic [2:0]            line_6,
  output logic                  missed
);

  localparam int unsigned CntW = (EMPTY_MOD > 1) ? $clog2(EMPTY_MOD) : 1;

  shift_state_e state_q, state_d;
  logic         do_shift;

  tile_t [NUM_ROWS-1:0] rows_q;
  logic                 missed_q;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_wrap;
  logic            force_empty;

  logic [15:0] lfsr_value;
  logic [13:0] lfsr_unused;
  tile_t       new_tile;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (do_shift),
    .seed  (SEED),
    .value (lfsr_value)
  );

  // Only the low two bits pick a lane; the rest are LFSR-internal state.
  assign lfsr_unused = lfsr_value[15:2];

  // Handshake FSM: one scroll per rising request, done held until go drops.
  always_comb begin
    state_d    = state_q;
    do_shift   = 1'b0;
    shift_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (shift_go) begin
          state_d = StShift;
        end
      end
      StShift: begin
        do_shift = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        // Gated by go so done falls together with the request.
        shift_done = shift_go;
        if (!shift_go) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Empty-row counter: the last slot of each EMPTY_MOD period is forced empty.
  always_comb begin
    cnt_wrap    = 1'b0;
    force_empty = 1'b0;
    cnt_d       = cnt_q;
    if (EMPTY_MOD != 0) begin
      cnt_wrap    = (32'(cnt_q) == EMPTY_MOD - 1);
      force_empty = cnt_wrap;
      if (do_shift) begin
        cnt_d = cnt_wrap ? '0 : cnt_q + CntW'(1);
      end
    end
  end

  // Empty-row counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tile entering row 0 on the next scroll.
  always_comb begin
    new_tile = TILE_EMPTY;
    if (!force_empty) begin
      new_tile = pick_lane(lfsr_value[1:0], rows_q[0]);
    end
  end

  // Board register: scroll beats clear; miss uses the pre-clear bottom row.
  always_ff @(posedge clock) begin
    if (reset) begin
      rows_q   <= '0;
      missed_q <= 1'b0;
    end else begin
      missed_q <= 1'b0;
      if (do_shift) begin
        rows_q   <= {rows_q[NUM_ROWS-2:0], new_tile};
        missed_q <= (rows_q[NUM_ROWS-1] != TILE_EMPTY);
      end else if (clear_bottom) begin
        rows_q[NUM_ROWS-1] <= TILE_EMPTY;
      end
    end
  end

  assign rows   = rows_q;
  assign line_6 = rows_q[NUM_ROWS-1];
  assign missed = missed_q;

endmodule

// File: tb/tb_tile_row_gen.sv
// Bench for tile_row_gen: two instances (seed ACE1 and seed 0) share the
// stimulus; a transaction-level board model is compared every cycle.
module tb_tile_row_gen;

  localparam int NR = 7;

  logic          clock;
  logic          reset;
  logic          shift_go;
  logic          clear_bottom;
  logic [3*NR-1:0] rows_a, rows_b;
  logic [2:0]    line_6_a, line_6_b;
  logic          done_a, done_b;
  logic          missed_a, missed_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  tile_row_gen #(.NUM_ROWS(NR), .SEED(16'hACE1), .EMPTY_MOD(4)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .shift_go     (shift_go),
    .shift_done   (done_a),
    .clear_bottom (clear_bottom),
    .rows         (rows_a),
    .line_6       (line_6_a),
    .missed       (missed_a)
  );

  tile_row_gen #(.NUM_ROWS(NR), .SEED(16'h0000), .EMPTY_MOD(4)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .shift_go     (shift_go),
    .shift_done   (done_b),
    .clear_bottom (clear_bottom),
    .rows         (rows_b),
    .line_6       (line_6_b),
    .missed       (missed_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- model ----------------
  logic [2:0]  m_rows   [2][NR];
  logic [15:0] m_lfsr   [2];
  int          m_cnt    [2];
  bit          m_missed [2];
  bit          m_pending;
  bit          m_complete;
  logic [15:0] m_seed   [2];

  function automatic logic [15:0] model_lfsr(logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic model_scroll(int k);
    int lane;
    m_missed[k] = (m_rows[k][NR-1] != 3'd0);
    if (m_cnt[k] == 3) begin
      lane = 0;
    end else begin
      lane = int'(m_lfsr[k][1:0]) + 1;
      if (lane == int'(m_rows[k][0])) lane = (lane % 4) + 1;
    end
    for (int i = NR - 1; i > 0; i--) m_rows[k][i] = m_rows[k][i-1];
    m_rows[k][0] = 3'(lane);
    m_lfsr[k] = model_lfsr(m_lfsr[k]);
    m_cnt[k] = (m_cnt[k] + 1) % 4;
  endtask

  // Inputs change 1 time unit after the edge, so they are stable here.
  initial begin
    m_seed[0] = 16'hACE1;
    m_seed[1] = 16'h0001;
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int k = 0; k < 2; k++) begin
          for (int i = 0; i < NR; i++) m_rows[k][i] = 3'd0;
          m_lfsr[k] = m_seed[k];
          m_cnt[k] = 0;
          m_missed[k] = 0;
        end
        m_pending = 0;
        m_complete = 0;
      end else begin
        m_missed[0] = 0;
        m_missed[1] = 0;
        if (m_pending) begin
          model_scroll(0);
          model_scroll(1);
          m_pending = 0;
          m_complete = 1;
        end else begin
          if (clear_bottom) begin
            m_rows[0][NR-1] = 3'd0;
            m_rows[1][NR-1] = 3'd0;
          end
          if (m_complete) begin
            if (!shift_go) m_complete = 0;
          end else if (shift_go) begin
            m_pending = 1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_one(input int k, input logic [3*NR-1:0] r, input logic [2:0] l6,
                             input logic d, input logic m, input logic [15:0] lf);
    logic [3*NR-1:0] e;
    for (int i = 0; i < NR; i++) e[3*i +: 3] = m_rows[k][i];
    check($sformatf("rows[%0d]", k), 32'(r), 32'(e));
    check($sformatf("line_6[%0d]", k), 32'(l6), 32'(m_rows[k][NR-1]));
    check($sformatf("shift_done[%0d]", k), 32'(d), 32'(m_complete && shift_go));
    check($sformatf("missed[%0d]", k), 32'(m), 32'(m_missed[k]));
    check($sformatf("lfsr[%0d]", k), 32'(lf), 32'(m_lfsr[k]));
    check($sformatf("lfsr_nonzero[%0d]", k), 32'(lf != 16'h0000), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        compare_one(0, rows_a, line_6_a, done_a, missed_a, dut_a.u_lfsr.value);
        compare_one(1, rows_b, line_6_b, done_b, missed_b, dut_b.u_lfsr.value);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset = 1'b1;
    shift_go = 1'b0;
    clear_bottom = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic handshake(output int misses);
    int waited;
    misses = 0;
    waited = 0;
    shift_go = 1'b1;
    do begin
      @(negedge clock);
      if (missed_a) misses++;
      waited++;
    end while (!done_a && waited < 10);
    if (!done_a) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: shift_done=%0b required 1", done_a);
    end
    @(posedge clock);
    #1 shift_go = 1'b0;
    @(negedge clock);
    if (missed_a) misses++;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_clear();
    clear_bottom = 1'b1;
    @(posedge clock);
    #1 clear_bottom = 1'b0;
  endtask

  task automatic scroll_until_bottom_full();
    int ms;
    for (int n = 0; n < 12 && m_rows[0][NR-1] == 3'd0; n++) handshake(ms);
  endtask

  initial begin
    int ms;
    logic [4:0] done_hist;
    logic [2:0] saved;

    do_reset();
    chk_en = 1;

    // Model pins: LFSR steps computed by hand.
    check("model_lfsr_ace1", 32'(model_lfsr(16'hACE1)), 32'h59C3);
    check("model_lfsr_59c3", 32'(model_lfsr(16'h59C3)), 32'hB387);
    check("reset_lfsr_a", 32'(dut_a.u_lfsr.value), 32'hACE1);
    check("reset_lfsr_b", 32'(dut_b.u_lfsr.value), 32'h0001);
    check("reset_rows_a", 32'(rows_a), 32'd0);

    // 1: go held 5 cycles -> one scroll, done in cycles 2..4.
    shift_go = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      done_hist[c] = done_a;
      @(posedge clock);
      #1;
    end
    shift_go = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("held_go_done_pattern", 32'(done_hist), 32'b11100);
    check("first_tile_a", 32'(rows_a[2:0]), 32'd2);
    check("first_tile_b", 32'(rows_b[2:0]), 32'd2);
    check("single_scroll_row1", 32'(rows_a[5:3]), 32'd0);

    // 2: 20 handshakes from reset.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      handshake(ms);
      if (i % 4 == 3) begin
        check("empty_slot", 32'(rows_a[2:0]), 32'd0);
      end else begin
        check("lane_range", 32'(rows_a[2:0] >= 3'd1 && rows_a[2:0] <= 3'd4), 32'd1);
        if (rows_a[5:3] != 3'd0) check("no_repeat_lane", 32'(rows_a[2:0] != rows_a[5:3]), 32'd1);
      end
      if (i == 1) begin
        check("tile1_a", 32'(rows_a[2:0]), 32'd4);
        check("tile1_b", 32'(rows_b[2:0]), 32'd3);
      end
      if (i == 2) begin
        check("tile2_a_rotated", 32'(rows_a[2:0]), 32'd1);
        check("tile2_b", 32'(rows_b[2:0]), 32'd1);
      end
    end

    // 3: unplayed bottom tile -> exactly one miss pulse; cleared -> none.
    scroll_until_bottom_full();
    handshake(ms);
    check("miss_pulse_count", 32'(ms), 32'd1);
    scroll_until_bottom_full();
    pulse_clear();
    check("cleared_line_6", 32'(line_6_a), 32'd0);
    handshake(ms);
    check("no_miss_after_clear", 32'(ms), 32'd0);

    // 4: clear during SHIFT is dropped and still counts as a miss.
    scroll_until_bottom_full();
    saved = m_rows[0][NR-2];
    shift_go = 1'b1;
    @(posedge clock);
    #1 clear_bottom = 1'b1;
    @(posedge clock);
    #1 clear_bottom = 1'b0;
    @(negedge clock);
    check("clear_in_shift_missed", 32'(missed_a), 32'd1);
    check("clear_in_shift_line_6", 32'(line_6_a), 32'(saved));
    @(posedge clock);
    #1 shift_go = 1'b0;
    @(posedge clock);
    #1;

    // 5: reset during SHIFT, then during DONE.
    shift_go = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 begin reset = 1'b0; shift_go = 1'b0; end
    @(negedge clock);
    check("rst_shift_rows", 32'(rows_a), 32'd0);
    check("rst_shift_done", 32'(done_a), 32'd0);
    check("rst_shift_missed", 32'(missed_a), 32'd0);
    check("rst_shift_lfsr", 32'(dut_a.u_lfsr.value), 32'hACE1);
    @(posedge clock);
    #1 shift_go = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 begin reset = 1'b0; shift_go = 1'b0; end
    @(negedge clock);
    check("rst_done_rows", 32'(rows_a), 32'd0);
    check("rst_done_done", 32'(done_a), 32'd0);
    check("rst_done_missed", 32'(missed_a), 32'd0);
    check("rst_done_lfsr_b", 32'(dut_b.u_lfsr.value), 32'h0001);
    @(posedge clock);
    #1;

    // 6: long run; the zero-seed instance must never hit zero.
    handshake(ms);
    check("zero_seed_first_lane", 32'(rows_b[2:0]), 32'd2);
    for (int i = 1; i < 1000; i++) handshake(ms);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
